cmp_bist: RTL and testbench
===========================

# cmp_bist

Built-in self-test engine for the `cmp` magnitude comparator used by the factorial datapath. It sweeps every operand pair (a, b) with 0 ≤ a, b < `limit_` into a comparator instance, and checks the returned `gt_` against an internal golden `a > b`. It counts mismatches and captures the first failing pair. It sits beside the comparator as the driving/checking end of the comparator's operand/result interface and runs either in hardware or standalone in simulation.

## Interface
- `SIZE_`, default 8: operand width, matching the comparator under test.
- `clk_`  in  1: clock; all state updates on rising edge.
- `rst_`  in  1: synchronous, active-high reset.
- `start_`  in  1: request a sweep; honoured only in IDLE.
- `limit_`  in  SIZE_: sweep bound L, sampled on the accepted start edge; pairs 0..L-1 × 0..L-1.
- `a_`  out  SIZE_: operand A to the comparator, registered.
- `b_`  out  SIZE_: operand B to the comparator, registered.
- `gt_`  in  1: comparator result for the current `a_`/`b_`.
- `busy_`  out  1: high from the cycle after the accepted start through the last CHECK cycle.
- `done_`  out  1: one-cycle pulse marking sweep completion.
- `pass_`  out  1: high when the last completed sweep had zero mismatches; held until the next accepted start.
- `err_count_`  out  2*SIZE_: mismatch count of the current or last sweep.
- `fail_a_`, `fail_b_`  out  SIZE_: first mismatching pair; valid when `err_count_` ≠ 0.

## Operation
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE with `start_`=1 and L≠0 → DRIVE. Latch L. Set a=b=0. Clear `err_count_`, `fail_a_`, `fail_b_` and `pass_`.
- IDLE with `start_`=1 and L=0 → DONE directly. No pairs are driven. `pass_`=1 and `err_count_`=0.
- DRIVE → CHECK unconditionally. This gives the comparator one full cycle to settle.
- CHECK: compare `gt_` with the unsigned `a_ > b_` result.
  - On mismatch, increment `err_count_`.
  - If the count was 0, also load `fail_a_`/`fail_b_`.
- CHECK ordering: b is the inner loop and a the outer loop.
  - If b < L-1: b++ and go to DRIVE.
  - Else if a < L-1: b=0, a++ and go to DRIVE.
  - Else go to DONE.
- DONE: `done_`=1 and `pass_` = (final count == 0); then go to IDLE. `a_`/`b_` keep their last pair.
- `start_` outside IDLE is ignored and never queued.
- Arithmetic: all compares are unsigned, SIZE_ bits wide. `err_count_` cannot overflow because L² ≤ (2^SIZE_-1)² < 2^(2*SIZE_). No saturation logic.
- Reset, including mid-sweep, has the same effect in every state:
  - Next state IDLE.
  - `a_`, `b_`, `busy_`, `done_`, `pass_`, `err_count_`, `fail_a_` and `fail_b_` all go to 0.
  - The latched L is discarded.

## Timing
- Edge E0 accepts start. Cycles are numbered after E0.
- Pair k (0-based, k = a·L + b) is presented in cycles 2k+1 (DRIVE) and 2k+2 (CHECK). `gt_` is sampled at the edge ending cycle 2k+2.
- `done_` is high in cycle 2L²+1 only, or cycle 1 when L=0. `busy_` is high in cycles 1..2L².
- `pass_`, `err_count_`, `fail_a_` and `fail_b_` are final when `done_` rises.
- Earliest next start: sampled in cycle 2L²+2, the first cycle back in IDLE.
- The comparator must be combinational: a one-cycle settle window within a single DRIVE cycle.

## Structure
- Shared header `cmp_defs.vh` holds:
  - FSM state encodings (2-bit: IDLE=0, DRIVE=1, CHECK=2, DONE=3).
  - Default SIZE_ value, shared with `cmp`.
- One sub-module is natural: `pair_counter`. It is a two-level nested counter with inputs `clr`, `inc` and `limit`, and outputs `a`, `b` and `last`, where `last` = (a==L-1 && b==L-1).
- The golden compare is inline and is not a `cmp` instance.

## Test plan
- Correct `cmp` (SIZE_=8), L=10 → 100 pairs; `done_` in cycle 201; `pass_`=1, `err_count_`=0; `busy_` high in cycles 1..200.
- Model `gt_` stuck at 0, L=10 → `err_count_`=45, `fail_a_`=1, `fail_b_`=0, `pass_`=0.
- Model `gt_` = ~(a>b), L=10 → `err_count_`=100, first fail (0,0); then re-run with a correct `cmp` → counters cleared at start, `pass_`=1.
- L=0 → `done_` in cycle 1, `pass_`=1, `err_count_`=0, `busy_` never high; L=1 → single pair (0,0), `done_` in cycle 3.
- Assert `rst_` in cycle 50 of an L=10 sweep → next cycle: all outputs 0, IDLE. A new start with L=3 then completes with `done_` in cycle 19.
- Pulse `start_` in cycles 5 and 7 of an active sweep → ignored; pair order, total length and results are unchanged.

Source files
------------

// File: rtl/cmp_bist_pkg.sv
// Shared definitions for the comparator BIST: sweep FSM encoding and default operand width.
package cmp_bist_pkg;

    localparam int unsigned SIZE_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cmp_bist_pair_counter.sv
// Two-level operand-pair counter: b is the inner loop, a the outer, both bounded by limit.
module pair_counter
    import cmp_bist_pkg::*;
#(
    parameter int unsigned SIZE_ = SIZE_DEFAULT
) (
    input  logic             clk_,
    input  logic             rst_,
    input  logic             clr,
    input  logic             inc,
    input  logic [SIZE_-1:0] limit,
    output logic [SIZE_-1:0] a,
    output logic [SIZE_-1:0] b,
    output logic             last
);

    logic [SIZE_-1:0] lim_m1;

    assign lim_m1 = limit - SIZE_'(1);
    assign last   = (a == lim_m1) && (b == lim_m1);

    // Wrap b at limit-1 and carry into a; inc is never issued on the last pair.
    always_ff @(posedge clk_) begin
        if (rst_) begin
            a <= '0;
            b <= '0;
        end else if (clr) begin
            a <= '0;
            b <= '0;
        end else if (inc) begin
            if (b == lim_m1) begin
                b <= '0;
                a <= a + SIZE_'(1);
            end else begin
                b <= b + SIZE_'(1);
            end
        end
    end

endmodule

// File: rtl/cmp_bist.sv
// Self-test engine for the cmp magnitude comparator: sweeps all operand pairs below a
// limit, checks gt_ against an inline a>b, counts mismatches and keeps the first one.
module cmp_bist
    import cmp_bist_pkg::*;
#(
    parameter int unsigned SIZE_ = SIZE_DEFAULT
) (
    input  logic               clk_,
    input  logic               rst_,
    input  logic               start_,
    input  logic [SIZE_-1:0]   limit_,
    output logic [SIZE_-1:0]   a_,
    output logic [SIZE_-1:0]   b_,
    input  logic               gt_,
    output logic               busy_,
    output logic               done_,
    output logic               pass_,
    output logic [2*SIZE_-1:0] err_count_,
    output logic [SIZE_-1:0]   fail_a_,
    output logic [SIZE_-1:0]   fail_b_
);

    localparam int unsigned CW = 2 * SIZE_;

    state_t           state_q, state_nxt;
    logic [SIZE_-1:0] lim_q, lim_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [CW-1:0]    err_nxt;
    logic [SIZE_-1:0] fail_a_nxt, fail_b_nxt;
    logic             cnt_clr, cnt_inc, cnt_last;
    logic             mismatch_c;

    pair_counter #(.SIZE_(SIZE_)) u_pair_counter (
        .clk_  (clk_),
        .rst_  (rst_),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (lim_q),
        .a     (a_),
        .b     (b_),
        .last  (cnt_last)
    );

    assign mismatch_c = (gt_ != (a_ > b_));

    always_ff @(posedge clk_) begin
        if (rst_) begin
            state_q    <= ST_IDLE;
            lim_q      <= '0;
            busy_      <= 1'b0;
            done_      <= 1'b0;
            pass_      <= 1'b0;
            err_count_ <= '0;
            fail_a_    <= '0;
            fail_b_    <= '0;
        end else begin
            state_q    <= state_nxt;
            lim_q      <= lim_nxt;
            busy_      <= busy_nxt;
            done_      <= done_nxt;
            pass_      <= pass_nxt;
            err_count_ <= err_nxt;
            fail_a_    <= fail_a_nxt;
            fail_b_    <= fail_b_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt  = state_q;
        lim_nxt    = lim_q;
        busy_nxt   = busy_;
        done_nxt   = 1'b0;
        pass_nxt   = pass_;
        err_nxt    = err_count_;
        fail_a_nxt = fail_a_;
        fail_b_nxt = fail_b_;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_) begin
                    lim_nxt    = limit_;
                    err_nxt    = '0;
                    fail_a_nxt = '0;
                    fail_b_nxt = '0;
                    if (limit_ != '0) begin
                        state_nxt = ST_DRIVE;
                        busy_nxt  = 1'b1;
                        pass_nxt  = 1'b0;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    err_nxt = err_count_ + CW'(1);
                    if (err_count_ == '0) begin
                        fail_a_nxt = a_;
                        fail_b_nxt = b_;
                    end
                end
                if (cnt_last) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    state_nxt = ST_DRIVE;
                    cnt_inc   = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cmp_bist.sv
// Randomised scoreboard bench for cmp_bist with a behavioural comparator that can be faulty.
module tb_cmp_bist;

    localparam int SZ = 8;

    typedef struct {
        int l;
        int mode;
        int err;
        int fa;
        int fb;
    } run_t;

    logic            clk_ = 1'b0;
    logic            rst_ = 1'b1;
    logic            start_ = 1'b0;
    logic [SZ-1:0]   limit_ = '0;
    logic [SZ-1:0]   a_, b_;
    logic            gt_;
    logic            busy_, done_, pass_;
    logic [2*SZ-1:0] err_count_;
    logic [SZ-1:0]   fail_a_, fail_b_;

    int   mode = 0;   // 0 correct, 1 stuck at 0, 2 inverted
    int   n_checks = 0;
    int   n_fail = 0;
    run_t exp_q[$];
    run_t cur;
    bit   active = 0;
    bit   expect_zero = 0;
    int   rel = 0;
    int   last_pass = 0, last_err = 0, last_fa = 0, last_fb = 0;

    always #5 clk_ = ~clk_;

    cmp_bist #(.SIZE_(SZ)) dut (
        .clk_       (clk_),
        .rst_       (rst_),
        .start_     (start_),
        .limit_     (limit_),
        .a_         (a_),
        .b_         (b_),
        .gt_        (gt_),
        .busy_      (busy_),
        .done_      (done_),
        .pass_      (pass_),
        .err_count_ (err_count_),
        .fail_a_    (fail_a_),
        .fail_b_    (fail_b_)
    );

    function automatic bit model_gt(int m, int a, int b);
        case (m)
            0:       return a > b;
            1:       return 1'b0;
            default: return !(a > b);
        endcase
    endfunction

    // Mismatches among the first k pairs of an L-sweep in row-major (a outer, b inner) order.
    function automatic int errs_upto(int l, int m, int k);
        int e = 0;
        for (int i = 0; i < k; i++) begin
            int a = i / l;
            int b = i % l;
            if (model_gt(m, a, b) != (a > b)) e++;
        end
        return e;
    endfunction

    assign gt_ = model_gt(mode, int'(a_), int'(b_));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Monitor: follows each accepted run cycle by cycle and checks every output.
    always @(negedge clk_) begin
        if (rst_) begin
            active = 0;
            exp_q.delete();
            expect_zero = 1;
        end else if (expect_zero) begin
            chk("rst_a", 32'(a_), 0);
            chk("rst_b", 32'(b_), 0);
            chk("rst_busy", 32'(busy_), 0);
            chk("rst_done", 32'(done_), 0);
            chk("rst_pass", 32'(pass_), 0);
            chk("rst_err", 32'(err_count_), 0);
            chk("rst_fail_a", 32'(fail_a_), 0);
            chk("rst_fail_b", 32'(fail_b_), 0);
            expect_zero = 0;
            last_pass = 0; last_err = 0; last_fa = 0; last_fb = 0;
        end else begin
            if (!active && exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                active = 1;
                rel = 0;
            end
            if (active) begin
                int n, tgt, e, k;
                rel++;
                n   = cur.l * cur.l;
                tgt = 2 * n + 1;
                e   = errs_upto(cur.l, cur.mode, (rel - 1) / 2);
                chk("busy", 32'(busy_), 32'(rel <= 2 * n));
                chk("done", 32'(done_), 32'(rel == tgt));
                chk("err_count", 32'(err_count_), 32'(e));
                chk("fail_a", 32'(fail_a_), 32'((e != 0) ? cur.fa : 0));
                chk("fail_b", 32'(fail_b_), 32'((e != 0) ? cur.fb : 0));
                chk("pass", 32'(pass_), 32'((rel == tgt) ? (cur.err == 0) : (n == 0)));
                if (n != 0) begin
                    k = (rel - 1) / 2;
                    if (k > n - 1) k = n - 1;
                    chk("pair_a", 32'(a_), 32'(k / cur.l));
                    chk("pair_b", 32'(b_), 32'(k % cur.l));
                end
                if (rel == tgt) begin
                    active = 0;
                    last_pass = (cur.err == 0);
                    last_err = cur.err;
                    last_fa = cur.fa;
                    last_fb = cur.fb;
                end
            end else begin
                chk("idle_busy", 32'(busy_), 0);
                chk("idle_done", 32'(done_), 0);
                chk("idle_pass", 32'(pass_), 32'(last_pass));
                chk("idle_err", 32'(err_count_), 32'(last_err));
                chk("idle_fail_a", 32'(fail_a_), 32'(last_fa));
                chk("idle_fail_b", 32'(fail_b_), 32'(last_fb));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((active || exp_q.size() != 0) && n < 2000) begin
            @(posedge clk_);
            n++;
        end
        chk("idle_wait_bound", 32'(n < 2000), 1);
    endtask

    // Issue one start and push the expected sweep outcome; returns #1 into cycle 1.
    task automatic start_run(input int l, input int m);
        run_t r;
        wait_idle();
        @(posedge clk_);
        #1;
        start_ = 1'b1;
        limit_ = SZ'(l);
        mode   = m;
        r.l = l;
        r.mode = m;
        r.err = errs_upto(l, m, l * l);
        r.fa = 0;
        r.fb = 0;
        for (int i = l * l - 1; i >= 0; i--)
            if (model_gt(m, i / l, i % l) != ((i / l) > (i % l))) begin
                r.fa = i / l;
                r.fb = i % l;
            end
        @(posedge clk_);
        exp_q.push_back(r);
        #1;
        start_ = 1'b0;
        limit_ = SZ'($urandom_range(0, 255));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_);
        #1;
        rst_ = 1'b0;

        start_run(10, 0);
        start_run(10, 1);
        start_run(10, 2);
        start_run(10, 0);
        start_run(0, 0);
        start_run(1, 0);
        start_run(1, 2);

        // Reset in cycle 50 of an L=10 sweep, then a clean L=3 sweep.
        start_run(10, 0);
        repeat (49) @(posedge clk_);
        #1;
        rst_ = 1'b1;
        @(posedge clk_);
        #1;
        rst_ = 1'b0;
        start_run(3, 0);

        // start_ pulses in cycles 5 and 7 of an active sweep must be ignored.
        start_run(10, 1);
        repeat (4) @(posedge clk_);
        #1;
        start_ = 1'b1;
        limit_ = SZ'(4);
        @(posedge clk_);
        #1;
        start_ = 1'b0;
        @(posedge clk_);
        #1;
        start_ = 1'b1;
        @(posedge clk_);
        #1;
        start_ = 1'b0;

        for (int i = 0; i < 8; i++)
            start_run(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)));

        wait_idle();
        repeat (3) @(posedge clk_);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
